// File: rtl/led_scan_display_if.sv
// rtl/led_scan_display_if.sv - position input and multiplexed 7-segment outputs
interface led_scan_display_if;
  logic [20:0] pos_in;
  logic [7:0]  led_en;
  logic [7:0]  led_seg;
  logic        err;

  modport master (output pos_in, input led_en, input led_seg, input err);
  modport slave  (input pos_in, output led_en, output led_seg, output err);
endinterface

// File: rtl/led_scan_display.sv
// rtl/led_scan_display.sv - one-hot position decode, lap counter and 8-digit scan
module led_scan_display #(
  parameter int SCAN_DIV = 200000
) (
  input  logic             clk,
  input  logic             rst,
  led_scan_display_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [20:0]      pos_q;
  logic [4:0]       idx_q;
  logic [4:0]       last_idx;
  logic             err_q;
  logic [3:0]       lap_t;
  logic [3:0]       lap_u;
  logic [DIV_W-1:0] div;
  logic [2:0]       sel;
  logic [7:0]       en_q;
  logic [7:0]       seg_q;
  logic             err_out_q;

  logic [4:0] ones;
  logic [4:0] idx_d;
  logic       valid;
  logic       lap_hit;
  logic [3:0] idx_tens;
  logic [3:0] idx_units;
  logic [7:0] dig_seg;
  logic       dig_blank;

  function automatic logic [7:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0: seg_code = 8'hC0;
      4'd1: seg_code = 8'hF9;
      4'd2: seg_code = 8'hA4;
      4'd3: seg_code = 8'hB0;
      4'd4: seg_code = 8'h99;
      4'd5: seg_code = 8'h92;
      4'd6: seg_code = 8'h82;
      4'd7: seg_code = 8'hF8;
      4'd8: seg_code = 8'h80;
      4'd9: seg_code = 8'h90;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    ones  = '0;
    idx_d = idx_q;
    for (int i = 0; i < 21; i++) begin
      if (pos_q[i]) begin
        ones  = ones + 5'd1;
        idx_d = 5'(i);
      end
    end
    valid   = (ones == 5'd1);
    lap_hit = valid && (idx_d == 5'd0) && (last_idx == 5'd20);
  end

  always_comb begin
    if (idx_q >= 5'd20) begin
      idx_tens  = 4'd2;
      idx_units = 4'(idx_q - 5'd20);
    end else if (idx_q >= 5'd10) begin
      idx_tens  = 4'd1;
      idx_units = 4'(idx_q - 5'd10);
    end else begin
      idx_tens  = 4'd0;
      idx_units = 4'(idx_q);
    end
  end

  // Leading zeros are blanked; an invalid position shows dashes on both index digits.
  always_comb begin
    dig_seg   = SEG_BLANK;
    dig_blank = 1'b1;
    case (sel)
      3'd0: begin
        dig_blank = 1'b0;
        dig_seg   = err_q ? SEG_DASH : seg_code(idx_units);
      end
      3'd1: begin
        if (err_q) begin
          dig_blank = 1'b0;
          dig_seg   = SEG_DASH;
        end else if (idx_tens != 4'd0) begin
          dig_blank = 1'b0;
          dig_seg   = seg_code(idx_tens);
        end
      end
      3'd6: begin
        dig_blank = 1'b0;
        dig_seg   = seg_code(lap_u);
      end
      3'd7: begin
        if (lap_t != 4'd0) begin
          dig_blank = 1'b0;
          dig_seg   = seg_code(lap_t);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q     <= 21'h000001;
      idx_q     <= '0;
      last_idx  <= '0;
      err_q     <= 1'b0;
      lap_t     <= '0;
      lap_u     <= '0;
      div       <= '0;
      sel       <= '0;
      en_q      <= 8'hFF;
      seg_q     <= 8'hFF;
      err_out_q <= 1'b0;
    end else begin
      pos_q <= bus.pos_in;
      err_q <= !valid;
      if (valid) begin
        idx_q    <= idx_d;
        last_idx <= idx_d;
      end
      if (lap_hit) begin
        if (lap_u == 4'd9) begin
          lap_u <= '0;
          lap_t <= (lap_t == 4'd9) ? 4'd0 : lap_t + 4'd1;
        end else begin
          lap_u <= lap_u + 4'd1;
        end
      end
      if (div == DIV_LAST) begin
        div <= '0;
        sel <= sel + 3'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
      en_q      <= dig_blank ? 8'hFF : ~(8'b1 << sel);
      seg_q     <= dig_blank ? SEG_BLANK : dig_seg;
      err_out_q <= err_q;
    end
  end

  assign bus.led_en  = en_q;
  assign bus.led_seg = seg_q;
  assign bus.err     = err_out_q;

endmodule

// File: tb/tb_led_scan_display.sv
// tb/tb_led_scan_display.sv - vector table, hand sequences and random run against a reference model
module tb_led_scan_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_scan_display_if bus4 ();
  led_scan_display_if bus1 ();

  led_scan_display #(.SCAN_DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  led_scan_display #(.SCAN_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [20:0] pos;
    int          dig;
    logic [7:0]  en;
    logic [7:0]  seg;
    logic        e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [20:0] cur;

  // Model: displayed index/error/lap, the position still to be decoded, edges since reset.
  int          m_idx, m_last, m_lap, m_n;
  logic        m_err;
  logic [20:0] m_pend;
  logic [16:0] exp4, exp1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [7:0] code(input int v);
    case (v)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [16:0] render(input int s);
    logic [7:0] sg;
    logic       blank;
    blank = 1'b0;
    sg    = 8'hFF;
    case (s)
      0: sg = m_err ? 8'hBF : code(m_idx % 10);
      1: if (m_err) sg = 8'hBF; else if (m_idx / 10 != 0) sg = code(m_idx / 10); else blank = 1'b1;
      6: sg = code(m_lap % 10);
      7: if (m_lap / 10 != 0) sg = code(m_lap / 10); else blank = 1'b1;
      default: blank = 1'b1;
    endcase
    if (blank) return {8'hFF, 8'hFF, m_err};
    return {~(8'h01 << s), sg, m_err};
  endfunction

  task automatic model_edge(input logic [20:0] p, input logic r);
    int k;
    if (r) begin
      exp4   = {8'hFF, 8'hFF, 1'b0};
      exp1   = exp4;
      m_idx  = 0;
      m_err  = 1'b0;
      m_last = 0;
      m_lap  = 0;
      m_pend = 21'h1;
      m_n    = 0;
    end else begin
      m_n++;
      exp4 = render(((m_n - 1) / 4) % 8);
      exp1 = render((m_n - 1) % 8);
      if (m_pend != 0 && (m_pend & (m_pend - 21'd1)) == 0) begin
        k = $clog2(m_pend);
        if (k == 0 && m_last == 20) m_lap = (m_lap + 1) % 100;
        m_last = k;
        m_idx  = k;
        m_err  = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_pend = p;
    end
  endtask

  task automatic tick(input logic [20:0] p, input logic r);
    cur         = p;
    bus4.pos_in = p;
    bus1.pos_in = p;
    rst         = r;
    @(posedge clk);
    model_edge(p, r);
    @(negedge clk);
    chk("model_dut4", {15'd0, bus4.led_en, bus4.led_seg, bus4.err}, {15'd0, exp4});
    chk("model_dut1", {15'd0, bus1.led_en, bus1.led_seg, bus1.err}, {15'd0, exp1});
  endtask

  // Hold the current position until SCAN_DIV=4 digit d is on the outputs, then compare.
  task automatic show(input int d, input logic [7:0] en, input logic [7:0] seg,
                      input logic e, input string nm);
    int guard;
    guard = 0;
    while (((m_n / 4) % 8) != d && guard < 40) begin
      tick(cur, 1'b0);
      guard++;
    end
    tick(cur, 1'b0);
    chk(nm, {15'd0, bus4.led_en, bus4.led_seg, bus4.err}, {15'd0, en, seg, e});
  endtask

  task automatic align(input int modv, input int phase);
    int guard;
    guard = 0;
    while ((m_n % modv) != phase && guard < 40) begin
      tick(cur, 1'b0);
      guard++;
    end
    chk("align", guard < 40, 1);
  endtask

  vec_t       tab [16];
  logic [7:0] scan_en [8];
  int         w;
  int         r;
  logic [20:0] p;

  initial begin
    tab[0]  = '{21'h1,       0, 8'hFE, 8'hC0, 1'b0};
    tab[1]  = '{21'h1,       6, 8'hBF, 8'hC0, 1'b0};
    tab[2]  = '{21'h1,       7, 8'hFF, 8'hFF, 1'b0};
    tab[3]  = '{21'h1,       3, 8'hFF, 8'hFF, 1'b0};
    tab[4]  = '{21'h1 << 13, 1, 8'hFD, 8'hF9, 1'b0};
    tab[5]  = '{21'h1 << 13, 0, 8'hFE, 8'hB0, 1'b0};
    tab[6]  = '{21'h1 << 20, 1, 8'hFD, 8'hA4, 1'b0};
    tab[7]  = '{21'h1 << 20, 0, 8'hFE, 8'hC0, 1'b0};
    tab[8]  = '{21'h0,       1, 8'hFD, 8'hBF, 1'b1};
    tab[9]  = '{21'h3,       0, 8'hFE, 8'hBF, 1'b1};
    tab[10] = '{21'h1 << 5,  0, 8'hFE, 8'h92, 1'b0};
    tab[11] = '{21'h1 << 5,  1, 8'hFF, 8'hFF, 1'b0};
    tab[12] = '{21'h1 << 5,  6, 8'hBF, 8'hC0, 1'b0};
    tab[13] = '{21'h1 << 9,  2, 8'hFF, 8'hFF, 1'b0};
    tab[14] = '{21'h1 << 9,  0, 8'hFE, 8'h90, 1'b0};
    tab[15] = '{21'h1 << 9,  5, 8'hFF, 8'hFF, 1'b0};
    scan_en = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hFF};

    for (int i = 0; i < 3; i++) begin
      tick(21'h1, 1'b1);
      chk("reset_out", {bus4.led_en, bus4.led_seg, bus4.err}, {8'hFF, 8'hFF, 1'b0});
    end

    foreach (tab[i]) begin
      for (int j = 0; j < 3; j++) tick(tab[i].pos, 1'b0);
      show(tab[i].dig, tab[i].en, tab[i].seg, tab[i].e, $sformatf("vec%0d", i));
    end

    // Index latency: new value reaches digit 0 on the third edge.
    for (int i = 0; i < 3; i++) tick(21'h1 << 2, 1'b0);
    align(32, 0);
    tick(21'h1 << 13, 1'b0);
    chk("lat_e1", bus4.led_seg, 8'hA4);
    tick(cur, 1'b0);
    chk("lat_e2", bus4.led_seg, 8'hA4);
    tick(cur, 1'b0);
    chk("lat_e3", {bus4.led_en, bus4.led_seg}, {8'hFE, 8'hB0});

    foreach (scan_en[i]) begin
      if (i < 4) begin
        tick(21'h1 << (18 + (i % 3)) & {21{i != 3}} | {20'd0, i == 3}, 1'b0);
        tick(cur, 1'b0);
      end
    end
    show(6, 8'hBF, 8'hF9, 1'b0, "lap1_u");
    show(7, 8'hFF, 8'hFF, 1'b0, "lap1_t");
    tick(21'h1 << 20, 1'b0); tick(cur, 1'b0);
    tick(21'h0, 1'b0);       tick(cur, 1'b0);
    tick(21'h1, 1'b0);       tick(cur, 1'b0);
    show(6, 8'hBF, 8'hA4, 1'b0, "lap2_glitch");

    // Lap latency: increment reaches digit 6 on the third edge after 0 arrives.
    for (int i = 0; i < 3; i++) tick(21'h1 << 20, 1'b0);
    align(32, 24);
    tick(21'h1, 1'b0);
    chk("laplat_e1", bus4.led_seg, 8'hA4);
    tick(cur, 1'b0);
    chk("laplat_e2", bus4.led_seg, 8'hA4);
    tick(cur, 1'b0);
    chk("laplat_e3", {bus4.led_en, bus4.led_seg}, {8'hBF, 8'hB0});

    for (int i = 0; i < 3; i++) tick(21'h1 << 13, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(cur, 1'b0);
      chk($sformatf("scan1_%0d", (m_n - 1) % 8), bus1.led_en, scan_en[(m_n - 1) % 8]);
    end

    // Lap is 3 here; 97 sweeps give 96 wraps.
    for (int s = 0; s < 97; s++)
      for (int v = 0; v < 21; v++) tick(21'h1 << v, 1'b0);
    show(7, 8'h7F, 8'h90, 1'b0, "lap99_t");
    show(6, 8'hBF, 8'h90, 1'b0, "lap99_u");
    for (int i = 0; i < 3; i++) tick(21'h1, 1'b0);
    show(7, 8'hFF, 8'hFF, 1'b0, "wrap_t");
    show(6, 8'hBF, 8'hC0, 1'b0, "wrap_u");

    w = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) w = (w + 1) % 21;
      p = 21'h1 << w;
      if (r == 8) p = 21'h0;
      if (r == 9) p = 21'($urandom);
      tick(p, 1'b0);
    end

    for (int i = 0; i < 3; i++) tick(21'h1 << 13, 1'b0);
    align(32, 22);
    tick(cur, 1'b1);
    chk("rst_mid", {bus4.led_en, bus4.led_seg, bus4.err}, {8'hFF, 8'hFF, 1'b0});
    tick(cur, 1'b0);
    chk("rst_sel0", {bus4.led_en, bus4.led_seg, bus4.err}, {8'hFE, 8'hC0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick(cur, 1'b0);
      chk("rst_slot", bus4.led_en, 8'hFE);
    end
    tick(cur, 1'b0);
    chk("rst_sel1", bus4.led_en, 8'hFD);
    show(6, 8'hBF, 8'hC0, 1'b0, "rst_lap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
